// File: rtl/keccak_pkg.sv
// Shared Keccak-f[1600] constants, state-array type and unpacker FSM encoding.
package keccak_pkg;

    localparam int LANE_W    = 64;
    localparam int NUM_LANES = 25;
    localparam int STATE_W   = 1600;

    // A[x][y][z], x and y in 0..4, z in 0..63
    typedef logic [0:4][0:4][0:LANE_W-1] state_array_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } fsm_state_t;

    // Bit offset of lane idx inside the flat state vector
    function automatic int lane_base(input int idx);
        return LANE_W * idx;
    endfunction

endpackage

// File: rtl/s_to_a.sv
// Combinational unpacking of the flat 1600-bit state into the A[x][y][z] array;
// inverse of the state-array-to-flat-vector packer.
import keccak_pkg::*;

module s_to_a (
    input  logic [STATE_W-1:0] s,
    output state_array_t       a
);

    for (genvar x = 0; x < 5; x++) begin : g_x
        for (genvar y = 0; y < 5; y++) begin : g_y
            for (genvar z = 0; z < LANE_W; z++) begin : g_z
                assign a[x][y][z] = s[lane_base(5 * y + x) + z];
            end
        end
    end

endmodule

// File: rtl/lane_stream_to_a.sv
// Receive-side lane unpacker: assembles RATE_LANES 64-bit lanes into the held
// Keccak state and offers it as A[x][y][z]. Define SPONGE_XOR_EN to XOR-absorb lanes.
import keccak_pkg::*;

module lane_stream_to_a #(
    parameter int RATE_LANES = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [LANE_W-1:0] in_lane,
    output logic              a_valid,
    input  logic              a_ready,
    output state_array_t      A
);

    localparam logic [4:0] LAST_LANE = 5'(RATE_LANES - 1);

    fsm_state_t         state_r;
    logic [4:0]         lane_cnt_r;
    logic [STATE_W-1:0] s_r;
    logic               in_ready_r;
    logic               a_valid_r;
    logic               accept_s;
    logic               last_s;
    logic [LANE_W-1:0]  lane_new_s [NUM_LANES];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane_new
`ifdef SPONGE_XOR_EN
        assign lane_new_s[i] = s_r[lane_base(i) +: LANE_W] ^ in_lane;
`else
        assign lane_new_s[i] = in_lane;
`endif
    end

    // Lane accept qualification and last-rate-lane detection
    always_comb begin
        accept_s = 1'b0;
        last_s   = 1'b0;
        if ((state_r == FILL) && in_valid) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        if (lane_cnt_r == LAST_LANE) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // FILL/HOLD sequencing, lane counter and state storage
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state_r    <= FILL;
            lane_cnt_r <= 5'd0;
            s_r        <= '0;
            in_ready_r <= 1'b1;
            a_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                FILL: begin
                    if (accept_s) begin
                        // Only rate lanes are reachable; capacity lanes keep their value
                        for (int i = 0; i < RATE_LANES; i++) begin
                            if (lane_cnt_r == 5'(i)) begin
                                s_r[lane_base(i) +: LANE_W] <= lane_new_s[i];
                            end
                        end
                        if (last_s) begin
                            lane_cnt_r <= 5'd0;
                            state_r    <= HOLD;
                            in_ready_r <= 1'b0;
                            a_valid_r  <= 1'b1;
                        end else begin
                            lane_cnt_r <= lane_cnt_r + 5'd1;
                        end
                    end
                end
                HOLD: begin
                    if (a_ready) begin
                        state_r    <= FILL;
                        in_ready_r <= 1'b1;
                        a_valid_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= FILL;
                    lane_cnt_r <= 5'd0;
                    in_ready_r <= 1'b1;
                    a_valid_r  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready = in_ready_r;
    assign a_valid  = a_valid_r;

    s_to_a u_s_to_a (
        .s (s_r),
        .a (A)
    );

endmodule

// File: tb/tb_lane_stream_to_a.sv
// Directed self-checking bench for lane_stream_to_a (default or SPONGE_XOR_EN build).
import keccak_pkg::*;

module tb_lane_stream_to_a;

    logic              clk;
    logic              rst;
    logic              clr;
    logic              in_valid;
    logic              in_ready;
    logic [LANE_W-1:0] in_lane;
    logic              a_valid;
    logic              a_ready;
    state_array_t      a_s;

    int total;
    int bad;

    logic [LANE_W-1:0] exp_l [NUM_LANES];
    state_array_t      exp_a;

    lane_stream_to_a #(.RATE_LANES(17)) dut (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_lane  (in_lane),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .A        (a_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_zero();
        for (int i = 0; i < NUM_LANES; i++) exp_l[i] = 64'h0;
    endtask

    task automatic model_lane(input int idx, input logic [63:0] v);
`ifdef SPONGE_XOR_EN
        exp_l[idx] = exp_l[idx] ^ v;
`else
        exp_l[idx] = v;
`endif
    endtask

    function automatic state_array_t build_a();
        state_array_t a;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                for (int z = 0; z < LANE_W; z++)
                    a[x][y][z] = exp_l[5 * y + x][z];
        return a;
    endfunction

    function automatic int diff_bits(input state_array_t a, input state_array_t b);
        return $countones(a ^ b);
    endfunction

    function automatic logic [63:0] lane_of(input state_array_t a, input int x, input int y);
        logic [63:0] l;
        for (int z = 0; z < LANE_W; z++) l[z] = a[x][y][z];
        return l;
    endfunction

    task automatic stream_lanes(input logic [63:0] v, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            in_valid = 1'b1;
            in_lane  = v;
            tick();
            model_lane(first + k, v);
        end
        in_valid = 1'b0;
    endtask

    task automatic consume();
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (a_s !== '0) begin bad++; $display("FAIL reset_state: got %0d set bits want 0", $countones(a_s)); end
    endtask

    task automatic test_fill_map();
        for (int i = 0; i < 17; i++) begin
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL fill_in_ready lane %0d: got %b want 1", i, in_ready); end
            in_valid = 1'b1;
            in_lane  = 64'h1 << i;
            tick();
            model_lane(i, 64'h1 << i);
            if (i == 15) begin
                total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL fill_early_valid: got %b want 0", a_valid); end
            end
        end
        in_valid = 1'b0;
        exp_a = build_a();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL fill_a_valid: got %b want 1", a_valid); end
        total++; if (a_s[1][0][1] !== 1'b1) begin bad++; $display("FAIL fill_A101: got %b want 1", a_s[1][0][1]); end
        total++; if (a_s[1][3][16] !== 1'b1) begin bad++; $display("FAIL fill_A1316: got %b want 1", a_s[1][3][16]); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL fill_state: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
        consume();
        total++; if (a_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL fill_release: got valid=%b ready=%b want 0/1", a_valid, in_ready); end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 17; i++) stream_lanes(64'h100 + 64'(i), i, 1);
        exp_a = build_a();
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1;
            in_lane  = 64'hFFFF;
            tick();
            total++; if (in_ready !== 1'b0 || a_valid !== 1'b1) begin bad++; $display("FAIL bp_hold cyc %0d: got ready=%b valid=%b want 0/1", c, in_ready, a_valid); end
            total++; if (a_s !== exp_a) begin bad++; $display("FAIL bp_stable cyc %0d: got %0d differing bits want 0", c, diff_bits(a_s, exp_a)); end
        end
        in_valid = 1'b0;
        consume();
        total++; if (in_ready !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got ready=%b valid=%b want 1/0", in_ready, a_valid); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL bp_after_release: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
        stream_lanes(64'h77, 0, 16);
        total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL bp_cnt_restart: got valid=%b want 0 after 16 lanes", a_valid); end
        stream_lanes(64'h77, 16, 1);
        exp_a = build_a();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL bp_second_frame: got valid=%b want 1", a_valid); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL bp_second_state: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
        consume();
    endtask

    task automatic test_gaps();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        for (int cyc = 1; cyc <= 33; cyc++) begin
            in_valid = (cyc % 2 == 1) ? 1'b1 : 1'b0;
            in_lane  = 64'h1 << ((cyc - 1) / 2);
            tick();
            if (cyc % 2 == 1) model_lane((cyc - 1) / 2, 64'h1 << ((cyc - 1) / 2));
            if (cyc == 32) begin
                total++; if (a_valid !== 1'b0) begin bad++; $display("FAIL gap_early: got valid=%b want 0 at cycle 32", a_valid); end
            end
        end
        in_valid = 1'b0;
        exp_a = build_a();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL gap_done: got valid=%b want 1 at cycle 33", a_valid); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL gap_state: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
        consume();
    endtask

    task automatic test_clr_mid_frame();
        stream_lanes(64'hDEAD_BEEF_0000_0000, 0, 8);
        in_valid = 1'b1;
        in_lane  = 64'hDEAD_BEEF_0000_0000;
        clr      = 1'b1;
        tick();
        clr      = 1'b0;
        in_valid = 1'b0;
        model_zero();
        total++; if (a_s !== '0) begin bad++; $display("FAIL clr_state: got %0d set bits want 0", $countones(a_s)); end
        total++; if (in_ready !== 1'b1 || a_valid !== 1'b0) begin bad++; $display("FAIL clr_flags: got ready=%b valid=%b want 1/0", in_ready, a_valid); end
        stream_lanes(64'h5, 0, 17);
        exp_a = build_a();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL clr_frame_valid: got %b want 1", a_valid); end
        total++; if (lane_of(a_s, 0, 0) !== 64'h5) begin bad++; $display("FAIL clr_lane0: got %h want 5", lane_of(a_s, 0, 0)); end
        total++; if (lane_of(a_s, 2, 3) !== 64'h0) begin bad++; $display("FAIL clr_cap_lane17: got %h want 0", lane_of(a_s, 2, 3)); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL clr_state_final: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
        consume();
    endtask

    task automatic test_sponge();
        logic [63:0] want;
`ifdef SPONGE_XOR_EN
        want = 64'h0;
`else
        want = 64'hA5A5_A5A5_A5A5_A5A5;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        stream_lanes(64'hA5A5_A5A5_A5A5_A5A5, 0, 17);
        consume();
        stream_lanes(64'hA5A5_A5A5_A5A5_A5A5, 0, 17);
        exp_a = build_a();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL sponge_valid: got %b want 1", a_valid); end
        total++; if (lane_of(a_s, 0, 0) !== want) begin bad++; $display("FAIL sponge_lane0: got %h want %h", lane_of(a_s, 0, 0), want); end
        total++; if (lane_of(a_s, 1, 3) !== want) begin bad++; $display("FAIL sponge_lane16: got %h want %h", lane_of(a_s, 1, 3), want); end
        total++; if (a_s !== exp_a) begin bad++; $display("FAIL sponge_state: got %0d differing bits want 0", diff_bits(a_s, exp_a)); end
    endtask

    task automatic test_rst_in_hold();
        total++; if (a_valid !== 1'b1) begin bad++; $display("FAIL rsthold_pre: got valid=%b want 1", a_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_zero();
        total++; if (a_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rsthold_flags: got valid=%b ready=%b want 0/1", a_valid, in_ready); end
        total++; if (a_s !== '0) begin bad++; $display("FAIL rsthold_state: got %0d set bits want 0", $countones(a_s)); end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        clr      = 1'b0;
        in_valid = 1'b0;
        in_lane  = 64'h0;
        a_ready  = 1'b0;
        model_zero();
        tick();
        test_reset();
        test_fill_map();
        test_backpressure();
        test_gaps();
        test_clr_mid_frame();
        test_sponge();
        test_rst_in_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lane_stream_to_a.md
Name: lane_stream_to_a

Overview:
- Sequential unpacker: the receive-side counterpart of the state-array-to-flat-vector packer.
- Accepts a stream of 64-bit lanes over a valid/ready handshake. Assembles RATE_LANES lanes into a held 1600-bit state.
- Presents the state as a Keccak state array A[x][y][z] to the permutation core, with its own valid/ready handshake.
- Sits between the SHAKE256 input framing/padding logic and the Keccak-f[1600] round core.

Parameters:
- RATE_LANES, 17, number of lanes per frame (1088-bit SHAKE256 rate); legal 1..25.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- clr  input  1  synchronous state clear; starts a new message.
- in_valid  input  1  in_lane is valid.
- in_ready  output  1  block can accept a lane.
- in_lane  input  64  lane data; bit z of lane i maps to A[i%5][i/5][z].
- a_valid  output  1  A holds a complete frame.
- a_ready  input  1  consumer takes the frame.
- A  output  [0:4][0:4][0:63]  unpacked state array; A[x][y][z] = S[64*(5y+x)+z].

Behaviour:
- Storage and counters:
  - State is held as a flat 1600-bit register S. Lane i occupies S[64i+63:64i].
  - lane_cnt is a 5-bit counter, range 0..RATE_LANES-1.
- FSM has two states, FILL and HOLD.
  - in_ready = (state==FILL).
  - a_valid = (state==HOLD).
- FILL:
  - On in_valid&&in_ready, write lane lane_cnt and increment lane_cnt.
  - When the accepted lane is lane RATE_LANES-1, lane_cnt wraps to 0 and the FSM goes to HOLD.
  - a_valid rises the cycle after the last lane is accepted; latency is 1 cycle.
- HOLD:
  - S and A are stable. in_valid is ignored and no lane is written.
  - On a_ready, go to FILL next cycle; in_ready=1 that cycle.
- Capacity lanes (index >= RATE_LANES) are never written by the stream. They change only via clr or rst.
- Gaps (in_valid=0) in FILL: counter and S hold.
- clr:
  - Next cycle S=0, lane_cnt=0, state=FILL.
  - clr has priority over a lane accept in the same cycle; that lane is dropped.
  - clr in HOLD drops the pending frame with no a_ready required.
- rst:
  - Has priority over everything; identical effect to clr.
  - Reset values: S=0 (A all 0), lane_cnt=0, state=FILL, a_valid=0, in_ready=1.
  - Reset mid-frame or in HOLD discards all data.
- A is pure wiring from S; no extra latency.

Optional Feature:
- Macro: SPONGE_XOR_EN.
- Defined: an accepted lane is XORed into the stored lane (S_lane <= S_lane ^ in_lane), implementing sponge absorb. State persists across frames until clr/rst.
- Undefined: an accepted lane overwrites the stored lane.
- All handshake, timing and capacity-lane rules are identical in both builds.

Decomposition:
- Shared package keccak_pkg:
  - constants LANE_W=64, NUM_LANES=25, STATE_W=1600;
  - typedef for the [0:4][0:4][0:63] state array;
  - FSM state enum {FILL, HOLD}.
- One sub-module, s_to_a:
  - purely combinational generate-loop wiring from the 1600-bit S to the A array;
  - exact inverse of the existing packer.
- The top holds the FSM, counter and S register.

Test Plan:
1. Lane fill and mapping.
   - Stimulus: rst, then stream lanes i=0..16 with in_lane = 64'h1<<i.
   - Required: a_valid=1 exactly one cycle after the 17th accept. A[1][0][1]=1 (i=1) and A[1][3][16]=1 (i=16). All other A bits 0, including lanes 17..24.
2. Output backpressure.
   - Stimulus: complete a frame, hold a_ready=0 for 5 cycles while in_valid=1 with lane 64'hFFFF.
   - Required: in_ready=0 and A unchanged throughout. a_ready=1 -> FILL next cycle, lane_cnt=0.
3. Input gaps.
   - Stimulus: alternate in_valid 1/0 for 17 lanes.
   - Required: frame completes after the 17th valid beat (cycle 33), contents as in scenario 1.
4. clr mid-frame.
   - Stimulus: accept 8 lanes of 64'hDEAD_BEEF_0000_0000, assert clr together with a 9th lane, then stream 17 lanes of 64'h5.
   - Required: the lane coinciding with clr is dropped. Final A rate lanes = 64'h5, capacity lanes = 0.
5. Optional feature.
   - Stimulus: two consecutive frames of identical lanes 64'hA5A5_A5A5_A5A5_A5A5.
   - Required:
     - SPONGE_XOR_EN defined: rate lanes = 0 after frame 2.
     - SPONGE_XOR_EN undefined: rate lanes = 64'hA5A5_A5A5_A5A5_A5A5.
6. rst in HOLD.
   - Stimulus: assert rst in HOLD.
   - Required: next cycle a_valid=0, in_ready=1, A all zero.
